ram16k_bist: RTL and testbench
==============================

RAM16K_BIST -- requirements
Module: ram16k_bist

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 14, meaning RAM address bits (depth 2^ADDRESS_WIDTH words).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning RAM word width.
REQ-003 The block SHALL have parameter SEED, default 16'h5A5A, meaning the pattern base; data for address a is (SEED + a) mod 2^DATA_WIDTH.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin a test run.
REQ-007 The block SHALL have port mem_address, output, ADDRESS_WIDTH, the address driven to the RAM16K address port.
REQ-008 The block SHALL have port mem_in, output, DATA_WIDTH, the write data driven to the RAM16K in port.
REQ-009 The block SHALL have port mem_load, output, 1, the write enable driven to the RAM16K load port.
REQ-010 The block SHALL have port mem_out, input, DATA_WIDTH, the RAM16K out port, combinational read of mem_address.
REQ-011 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 The block SHALL have port done, output, 1, high once a run completes; held until the next start or reset.
REQ-013 The block SHALL have port pass, output, 1, valid when done: 1 = zero mismatches.
REQ-014 The block SHALL have port err_count, output, 16, saturating mismatch count.
REQ-015 The block SHALL have port first_err_addr, output, ADDRESS_WIDTH, address of the first mismatch; 0 if none.

Function
REQ-016 The block SHALL implement states IDLE, WRITE, READ, DONE, with a registered address counter addr.
REQ-017 In IDLE or DONE, start=1 SHALL move to WRITE at the next edge, with addr=0, err_count=0, first_err_addr=0, done=0, pass=0.
REQ-018 In WRITE, each cycle SHALL drive mem_load=1, mem_address=addr, and mem_in=SEED+addr, and increment addr.
REQ-019 When addr=2^ADDRESS_WIDTH-1 in WRITE, that write SHALL complete and the next state SHALL be READ with addr wrapping to 0.
REQ-020 In READ, each cycle SHALL drive mem_load=0 and mem_address=addr, and SHALL compare mem_out against SEED+addr in the same cycle.
REQ-021 On a READ mismatch, err_count SHALL increment, saturating at 16'hFFFF; if it was 0, first_err_addr SHALL capture addr.
REQ-022 When addr=2^ADDRESS_WIDTH-1 in READ, that compare SHALL be counted and the next state SHALL be DONE.
REQ-023 On entry to DONE, done SHALL be 1 and pass SHALL equal (final err_count==0); both SHALL be registered.
REQ-024 busy SHALL be 1 exactly in WRITE and READ; a run SHALL take 2*2^ADDRESS_WIDTH cycles from the start edge to done=1.
REQ-025 start asserted during WRITE or READ SHALL be ignored.
REQ-026 Pattern arithmetic SHALL wrap modulo 2^DATA_WIDTH; SEED+addr SHALL be zero-extended before addition.
REQ-027 mem_load SHALL be 0 in every state except WRITE; mem_in SHALL be 0 outside WRITE.

Reset
REQ-028 reset=1 SHALL, at the next edge, force IDLE, addr=0, and all outputs to 0, including mem_load, busy, done, pass, err_count, and first_err_addr.
REQ-029 reset SHALL take priority over start in the same cycle.
REQ-030 A reset mid-run SHALL abort the run with no further writes; a later start SHALL rerun from address 0.

Verification
REQ-031 ADDRESS_WIDTH=4 with a fault-free RAM16K model; pulse start -> 16 writes of 5A5A..5A69, then 16 reads, then done=1, pass=1, err_count=0 at cycle 32 after start.
REQ-032 The RAM model SHALL have bit 0 stuck at 0 at address 5 (expected 5A5F) -> done=1, pass=0, err_count=1, first_err_addr=5.
REQ-033 The RAM model SHALL force every read to 0000 -> err_count=16, first_err_addr=0, pass=0.
REQ-034 Assert reset during WRITE at addr=7 -> next cycle mem_load=0, busy=0, state IDLE; a restart then yields pass=1.
REQ-035 Pulse start while busy at READ addr=3 -> no restart, and completion occurs on the original schedule.
REQ-036 SEED=16'hFFF8 -> address 8 is written 0000 (wrap), and the run passes.

Source files
------------

// File: rtl/ram16k_bist.sv
// March-style write-then-read BIST for a RAM16K-like memory: writes SEED+addr
// to every word, reads it back, and reports mismatch count and first failing address.
module ram16k_bist #(
   parameter int unsigned ADDRESS_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(16'h5A5A)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_in,
   output logic                     mem_load,
   input  logic [DATA_WIDTH-1:0]    mem_out,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [15:0]              err_count,
   output logic [ADDRESS_WIDTH-1:0] first_err_addr
);

   localparam int unsigned ERR_WIDTH = 16;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ERR_WIDTH-1:0]     ERR_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [ERR_WIDTH-1:0]     r_err_count;
   logic [ADDRESS_WIDTH-1:0] r_first_err_addr;
   logic                     r_done;
   logic                     r_pass;

   logic [DATA_WIDTH-1:0]    w_pattern;
   logic                     w_last;
   logic                     w_mismatch;
   logic                     w_err_inc;
   logic [ERR_WIDTH-1:0]     w_err_next;

   // Address is zero-extended before the add so the pattern wraps mod 2^DATA_WIDTH.
   assign w_pattern  = SEED + DATA_WIDTH'(r_addr);
   assign w_last     = (r_addr == LAST_ADDR);
   assign w_mismatch = (r_state == S_READ) && (mem_out != w_pattern);
   assign w_err_inc  = w_mismatch && (r_err_count != ERR_MAX);
   assign w_err_next = w_err_inc ? r_err_count + ERR_WIDTH'(1) : r_err_count;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic; start is only honoured from IDLE or DONE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start)  w_state_next = S_WRITE;
         S_WRITE:        if (w_last) w_state_next = S_READ;
         S_READ:         if (w_last) w_state_next = S_DONE;
         default:        w_state_next = S_IDLE;
      endcase
   end

   // Output decode from the state register
   always_comb begin
      mem_load    = 1'b0;
      mem_in      = '0;
      busy        = 1'b0;
      mem_address = r_addr;
      case (r_state)
         S_WRITE: begin
            mem_load = 1'b1;
            mem_in   = w_pattern;
            busy     = 1'b1;
         end
         S_READ:  busy = 1'b1;
         default: ;
      endcase
   end

   // Address counter and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr           <= '0;
         r_err_count      <= '0;
         r_first_err_addr <= '0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_addr           <= '0;
                  r_err_count      <= '0;
                  r_first_err_addr <= '0;
                  r_done           <= 1'b0;
                  r_pass           <= 1'b0;
               end
            end
            S_WRITE: r_addr <= r_addr + ADDRESS_WIDTH'(1);
            S_READ: begin
               r_addr      <= r_addr + ADDRESS_WIDTH'(1);
               r_err_count <= w_err_next;
               if (w_mismatch && (r_err_count == '0)) r_first_err_addr <= r_addr;
               if (w_last) begin
                  r_done <= 1'b1;
                  r_pass <= (w_err_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign err_count      = r_err_count;
   assign first_err_addr = r_first_err_addr;
   assign done           = r_done;
   assign pass           = r_pass;

endmodule

// File: tb/tb_ram16k_bist.sv
// Directed bench for ram16k_bist at ADDRESS_WIDTH=4 with a behavioural RAM that can inject faults;
// a second instance with SEED=16'hFFF8 checks pattern wrap-around.
module tb_ram16k_bist;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   int   fault_mode = 0;
   int   checks = 0;
   int   failures = 0;

   logic [AW-1:0] a_addr, a_first, b_addr, b_first;
   logic [DW-1:0] a_in, a_out, b_in, b_out;
   logic          a_load, a_busy, a_done, a_pass;
   logic          b_load, b_busy, b_done, b_pass;
   logic [15:0]   a_err, b_err;
   logic [DW-1:0] ram_a [DEPTH];
   logic [DW-1:0] ram_b [DEPTH];

   always #5 clk = ~clk;

   ram16k_bist #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SEED(16'h5A5A)) u_dut_a (
      .clk(clk), .reset(reset), .start(start),
      .mem_address(a_addr), .mem_in(a_in), .mem_load(a_load), .mem_out(a_out),
      .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_count(a_err), .first_err_addr(a_first)
   );

   ram16k_bist #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SEED(16'hFFF8)) u_dut_b (
      .clk(clk), .reset(reset), .start(start),
      .mem_address(b_addr), .mem_in(b_in), .mem_load(b_load), .mem_out(b_out),
      .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_count(b_err), .first_err_addr(b_first)
   );

   // RAM models: synchronous write, combinational read
   always @(posedge clk) begin
      if (a_load) ram_a[a_addr] <= a_in;
      if (b_load) ram_b[b_addr] <= b_in;
   end

   always_comb begin
      a_out = ram_a[a_addr];
      if (fault_mode == 1 && a_addr == 4'd5) a_out[0] = 1'b0;
      if (fault_mode == 2) a_out = '0;
      b_out = ram_b[b_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive start for exactly one edge; returns 1ns after that edge (cycle 0 of the run)
   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      step(2);
      start = 1'b0;
      checks++;
      if ({a_load, a_busy, a_done, a_pass} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {a_load, a_busy, a_done, a_pass});
      end
      checks++;
      if ({a_err, a_first, a_addr, a_in} !== 40'h0) begin
         failures++;
         $display("FAIL reset_values err=%h first=%h addr=%h in=%h exp=all0", a_err, a_first, a_addr, a_in);
      end
      reset = 1'b0;
      step(2);
      checks++;
      if ({a_busy, a_done, a_load} !== 3'b000) begin
         failures++;
         $display("FAIL idle_hold got=%b exp=000", {a_busy, a_done, a_load});
      end
   endtask

   task automatic test_fault_free();
      fault_mode = 0;
      pulse_start();
      for (int c = 0; c < 32; c++) begin
         logic [AW-1:0] exp_addr;
         logic [DW-1:0] exp_in;
         exp_addr = AW'(c % 16);
         exp_in   = (c < 16) ? 16'h5A5A + 16'(c) : 16'h0000;
         checks++;
         if (a_load !== (c < 16) || a_addr !== exp_addr || a_in !== exp_in || a_busy !== 1'b1 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL run_cycle%0d load=%b addr=%h in=%h busy=%b done=%b exp load=%b addr=%h in=%h busy=1 done=0",
                     c, a_load, a_addr, a_in, a_busy, a_done, (c < 16), exp_addr, exp_in);
         end
         step(1);
      end
      checks++;
      if ({a_done, a_pass, a_busy, a_load} !== 4'b1100 || a_err !== 16'd0 || a_first !== 4'd0) begin
         failures++;
         $display("FAIL clean_result done=%b pass=%b busy=%b load=%b err=%0d first=%0d exp 1 1 0 0 0 0",
                  a_done, a_pass, a_busy, a_load, a_err, a_first);
      end
   endtask

   task automatic test_stuck_bit();
      fault_mode = 1;
      pulse_start();
      step(32);
      checks++;
      if ({a_done, a_pass} !== 2'b10 || a_err !== 16'd1 || a_first !== 4'd5) begin
         failures++;
         $display("FAIL stuck_bit done=%b pass=%b err=%0d first=%0d exp done=1 pass=0 err=1 first=5",
                  a_done, a_pass, a_err, a_first);
      end
   endtask

   task automatic test_all_zero();
      fault_mode = 2;
      pulse_start();
      step(31);
      checks++;
      if (a_done !== 1'b0 || a_err !== 16'd15) begin
         failures++;
         $display("FAIL all_zero_pre done=%b err=%0d exp done=0 err=15", a_done, a_err);
      end
      step(1);
      checks++;
      if ({a_done, a_pass} !== 2'b10 || a_err !== 16'd16 || a_first !== 4'd0) begin
         failures++;
         $display("FAIL all_zero done=%b pass=%b err=%0d first=%0d exp done=1 pass=0 err=16 first=0",
                  a_done, a_pass, a_err, a_first);
      end
      fault_mode = 0;
   endtask

   task automatic test_reset_mid_write();
      fault_mode = 0;
      pulse_start();
      step(7);
      checks++;
      if (a_load !== 1'b1 || a_addr !== 4'd7) begin
         failures++;
         $display("FAIL pre_abort load=%b addr=%h exp load=1 addr=7", a_load, a_addr);
      end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++;
      if ({a_load, a_busy, a_done, a_pass} !== 4'b0000 || a_addr !== 4'd0 || a_in !== 16'h0) begin
         failures++;
         $display("FAIL abort load=%b busy=%b done=%b pass=%b addr=%h in=%h exp all0",
                  a_load, a_busy, a_done, a_pass, a_addr, a_in);
      end
      step(3);
      checks++;
      if ({a_load, a_busy} !== 2'b00) begin
         failures++;
         $display("FAIL abort_idle load=%b busy=%b exp 00", a_load, a_busy);
      end
      pulse_start();
      checks++;
      if (a_addr !== 4'd0 || a_in !== 16'h5A5A || a_load !== 1'b1) begin
         failures++;
         $display("FAIL restart addr=%h in=%h load=%b exp addr=0 in=5a5a load=1", a_addr, a_in, a_load);
      end
      step(32);
      checks++;
      if ({a_done, a_pass} !== 2'b11 || a_err !== 16'd0) begin
         failures++;
         $display("FAIL restart_result done=%b pass=%b err=%0d exp 1 1 0", a_done, a_pass, a_err);
      end
   endtask

   task automatic test_start_while_busy();
      pulse_start();
      step(19);
      checks++;
      if (a_load !== 1'b0 || a_addr !== 4'd3 || a_busy !== 1'b1) begin
         failures++;
         $display("FAIL read3 load=%b addr=%h busy=%b exp load=0 addr=3 busy=1", a_load, a_addr, a_busy);
      end
      pulse_start();
      checks++;
      if (a_load !== 1'b0 || a_addr !== 4'd4) begin
         failures++;
         $display("FAIL ignored_start load=%b addr=%h exp load=0 addr=4", a_load, a_addr);
      end
      step(11);
      checks++;
      if (a_done !== 1'b0 || a_addr !== 4'd15) begin
         failures++;
         $display("FAIL original_schedule done=%b addr=%h exp done=0 addr=f", a_done, a_addr);
      end
      step(1);
      checks++;
      if ({a_done, a_pass, a_busy} !== 3'b110) begin
         failures++;
         $display("FAIL busy_start_done done=%b pass=%b busy=%b exp 110", a_done, a_pass, a_busy);
      end
   endtask

   task automatic test_back_to_back();
      step(5);
      checks++;
      if ({a_done, a_pass} !== 2'b11) begin
         failures++;
         $display("FAIL done_hold done=%b pass=%b exp 11", a_done, a_pass);
      end
      pulse_start();
      checks++;
      if ({a_done, a_pass, a_busy, a_load} !== 4'b0011 || a_err !== 16'd0) begin
         failures++;
         $display("FAIL rerun_from_done done=%b pass=%b busy=%b load=%b err=%0d exp 0 0 1 1 0",
                  a_done, a_pass, a_busy, a_load, a_err);
      end
      step(32);
      checks++;
      if ({a_done, a_pass} !== 2'b11) begin
         failures++;
         $display("FAIL rerun_result done=%b pass=%b exp 11", a_done, a_pass);
      end
   endtask

   task automatic test_seed_wrap();
      pulse_start();
      checks++;
      if (b_in !== 16'hFFF8 || b_load !== 1'b1) begin
         failures++;
         $display("FAIL seed_addr0 in=%h load=%b exp in=fff8 load=1", b_in, b_load);
      end
      step(8);
      checks++;
      if (b_addr !== 4'd8 || b_in !== 16'h0000 || b_load !== 1'b1) begin
         failures++;
         $display("FAIL seed_wrap addr=%h in=%h load=%b exp addr=8 in=0000 load=1", b_addr, b_in, b_load);
      end
      step(7);
      checks++;
      if (b_in !== 16'h0007) begin
         failures++;
         $display("FAIL seed_addr15 in=%h exp 0007", b_in);
      end
      step(17);
      checks++;
      if ({b_done, b_pass} !== 2'b11 || b_err !== 16'd0) begin
         failures++;
         $display("FAIL seed_result done=%b pass=%b err=%0d exp 1 1 0", b_done, b_pass, b_err);
      end
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_stuck_bit();
      test_all_zero();
      test_reset_mid_write();
      test_start_while_busy();
      test_back_to_back();
      test_seed_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
